// File: rtl/md_sequencer_pkg.sv
// Shared types, constants and helpers for the RV32M multiply/divide sequencer.
package md_sequencer_pkg;

  localparam int XLEN = 32;
  localparam int CW   = $clog2(XLEN);

  // Sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // funct3 codes of the M extension.
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic op_b_signed(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

  // Two's complement negation of one XLEN word.
  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Shift-add multiplier / restoring divider datapath working on operand magnitudes.
// A single 2*XLEN register holds {product} for multiply and {remainder, quotient}
// for divide; the sign fix-up is applied combinationally on the way out.
module md_datapath
  import md_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] fix_result
);

  logic [2*XLEN-1:0] prod_r;
  logic [XLEN-1:0]   opnd_r;
  logic [2:0]        func3_r;
  logic              neg_a_r;
  logic              neg_b_r;

  logic              neg_a_s;
  logic              neg_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic [XLEN:0]     add_x_s;
  logic [XLEN:0]     add_y_s;
  logic              add_sub_s;
  logic [XLEN+1:0]   add_full_s;
  logic [2*XLEN-1:0] prod_next_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;

  // Operand sign flags and magnitudes from the live request.
  always_comb begin
    neg_a_s = op_a_signed(func3) & op_a[XLEN-1];
    neg_b_s = op_b_signed(func3) & op_b[XLEN-1];
    mag_a_s = neg_a_s ? neg_word(op_a) : op_a;
    mag_b_s = neg_b_s ? neg_word(op_b) : op_b;
  end

  // Shared XLEN+1-bit adder: add multiplicand for multiply, trial-subtract divisor for divide.
  always_comb begin
    add_y_s = {1'b0, opnd_r};
    if (func3_r[2]) begin
      add_x_s   = prod_r[2*XLEN-1:XLEN-1];
      add_sub_s = 1'b1;
    end else begin
      add_x_s   = {1'b0, prod_r[2*XLEN-1:XLEN]};
      add_sub_s = 1'b0;
    end
    add_full_s = {1'b0, add_x_s} + {1'b0, (add_sub_s ? ~add_y_s : add_y_s)}
               + {{(XLEN+1){1'b0}}, add_sub_s};
  end

  // Next value of the product / remainder-quotient register for one iteration.
  always_comb begin
    if (func3_r[2]) begin
      // Carry out of the subtract means the shifted remainder >= divisor.
      if (add_full_s[XLEN+1]) begin
        prod_next_s = {add_full_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
      end else begin
        prod_next_s = {prod_r[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (prod_r[0]) begin
        prod_next_s = {add_full_s[XLEN:0], prod_r[XLEN-1:1]};
      end else begin
        prod_next_s = {1'b0, prod_r[2*XLEN-1:1]};
      end
    end
  end

  // Operand capture on load, one iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r  <= {(2*XLEN){1'b0}};
      opnd_r  <= {XLEN{1'b0}};
      func3_r <= 3'b000;
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
    end else if (load) begin
      func3_r <= func3;
      neg_a_r <= neg_a_s;
      neg_b_r <= neg_b_s;
      if (func3[2]) begin
        prod_r <= {{XLEN{1'b0}}, mag_a_s};
        opnd_r <= mag_b_s;
      end else begin
        prod_r <= {{XLEN{1'b0}}, mag_b_s};
        opnd_r <= mag_a_s;
      end
    end else if (step) begin
      prod_r <= prod_next_s;
    end
  end

  // Sign fix-up and result selection.
  always_comb begin
    prod_fix_s = (neg_a_r ^ neg_b_r) ? (~prod_r + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_r;
    quo_fix_s  = (neg_a_r ^ neg_b_r) ? neg_word(prod_r[XLEN-1:0]) : prod_r[XLEN-1:0];
    rem_fix_s  = neg_a_r ? neg_word(prod_r[2*XLEN-1:XLEN]) : prod_r[2*XLEN-1:XLEN];
    case (func3_r)
      MD_MUL:                         fix_result = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:   fix_result = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:                fix_result = quo_fix_s;
      MD_REM, MD_REMU:                fix_result = rem_fix_s;
      default:                        fix_result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, divide special cases
// and the stall/done handshake with the execute stage.
module md_sequencer
  import md_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            md_req,
  input  logic [2:0]      md_func3,
  input  logic [XLEN-1:0] md_op_a,
  input  logic [XLEN-1:0] md_op_b,
  input  logic            md_kill,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  md_state_e       state_r;
  logic [CW-1:0]   count_r;

  logic            accept_s;
  logic            abort_s;
  logic            special_s;
  logic [XLEN-1:0] special_val_s;
  logic            load_s;
  logic            step_s;
  logic [XLEN-1:0] fix_result_s;

  // Handshake decode: stall holds the front end until the result is presented.
  assign md_stall = md_req & (state_r != MD_DONE) & ~md_kill & ~rst;
  assign accept_s = (state_r == MD_IDLE) & md_req & ~md_kill;
  assign abort_s  = md_kill | ~md_req;
  assign load_s   = accept_s & ~special_s;
  assign step_s   = (state_r == MD_CALC) & ~abort_s;

  // Divide-by-zero and signed overflow finish without iterating.
  always_comb begin
    special_s     = 1'b0;
    special_val_s = {XLEN{1'b0}};
    if (md_func3[2]) begin
      if (md_op_b == {XLEN{1'b0}}) begin
        special_s     = 1'b1;
        special_val_s = md_func3[1] ? md_op_a : {XLEN{1'b1}};
      end else if (!md_func3[0] && (md_op_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (md_op_b == {XLEN{1'b1}})) begin
        special_s     = 1'b1;
        special_val_s = md_func3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
        special_s     = 1'b0;
        special_val_s = {XLEN{1'b0}};
      end
    end else begin
      special_s     = 1'b0;
      special_val_s = {XLEN{1'b0}};
    end
  end

  md_datapath u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .step       (step_s),
    .func3      (md_func3),
    .op_a       (md_op_a),
    .op_b       (md_op_b),
    .fix_result (fix_result_s)
  );

  // Sequencer FSM with registered done pulse and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= MD_IDLE;
      count_r   <= {CW{1'b0}};
      md_done   <= 1'b0;
      md_result <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        MD_IDLE: begin
          md_done <= 1'b0;
          if (accept_s && special_s) begin
            md_result <= special_val_s;
            md_done   <= 1'b1;
            state_r   <= MD_DONE;
          end else if (accept_s) begin
            count_r <= CW'(XLEN - 1);
            state_r <= MD_CALC;
          end else begin
            state_r <= MD_IDLE;
          end
        end
        MD_CALC: begin
          md_done <= 1'b0;
          if (abort_s) begin
            state_r <= MD_IDLE;
          end else if (count_r == {CW{1'b0}}) begin
            state_r <= MD_FIX;
          end else begin
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        MD_FIX: begin
          if (abort_s) begin
            md_done <= 1'b0;
            state_r <= MD_IDLE;
          end else begin
            md_result <= fix_result_s;
            md_done   <= 1'b1;
            state_r   <= MD_DONE;
          end
        end
        MD_DONE: begin
          md_done <= 1'b0;
          state_r <= MD_IDLE;
        end
        default: begin
          md_done <= 1'b0;
          state_r <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            md_req;
  logic [2:0]      md_func3;
  logic [XLEN-1:0] md_op_a;
  logic [XLEN-1:0] md_op_b;
  logic            md_kill;
  logic            md_stall;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  int              tests = 0;
  int              fails = 0;
  logic [31:0]     last_res;

  md_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .md_req    (md_req),
    .md_func3  (md_func3),
    .md_op_a   (md_op_a),
    .md_op_b   (md_op_b),
    .md_kill   (md_kill),
    .md_stall  (md_stall),
    .md_done   (md_done),
    .md_result (md_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at the start of a cycle and check every cycle up to its done cycle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    md_req   = 1'b1;
    md_func3 = f;
    md_op_a  = a;
    md_op_b  = b;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check({tag, " stall"}, {31'd0, md_stall}, {31'd0, (c < lat)});
      check({tag, " done"}, {31'd0, md_done}, {31'd0, (c == lat)});
      if (c == 0) check({tag, " held"}, md_result, last_res);
      if (c == lat) check({tag, " result"}, md_result, exp);
      @(posedge clk);
      #1;
    end
    md_req   = 1'b0;
    last_res = exp;
  endtask

  initial begin
    rst      = 1'b1;
    md_req   = 1'b0;
    md_func3 = 3'b000;
    md_op_a  = 32'd0;
    md_op_b  = 32'd0;
    md_kill  = 1'b0;
    last_res = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    md_req = 1'b1;
    @(negedge clk);
    check("reset stall", {31'd0, md_stall}, 32'd0);
    check("reset done", {31'd0, md_done}, 32'd0);
    check("reset result", md_result, 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    md_req = 1'b0;

    // Divide special cases finish in the cycle after accept.
    run_op("div_by0",  MD_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", MD_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Iterative multiply variants.
    run_op("mul",    MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulh",   MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

    // Iterative divide variants.
    run_op("div",  MD_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem",  MD_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd3, 34);
    run_op("remu", MD_REMU, 32'd7, 32'd2, 32'd1, 34);

    // Kill a DIV in cycle 10, then a MUL issued in cycle 11 completes in cycle 45.
    md_req   = 1'b1;
    md_func3 = MD_DIV;
    md_op_a  = 32'd100;
    md_op_b  = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("kill pre stall", {31'd0, md_stall}, 32'd1);
      check("kill pre done", {31'd0, md_done}, 32'd0);
      @(posedge clk);
      #1;
    end
    md_kill = 1'b1;
    @(negedge clk);
    check("kill stall", {31'd0, md_stall}, 32'd0);
    check("kill done", {31'd0, md_done}, 32'd0);
    check("kill result", md_result, last_res);
    @(posedge clk);
    #1;
    md_kill = 1'b0;
    run_op("kill_mul", MD_MUL, 32'd6, 32'd7, 32'd42, 34);

    // Back-to-back: second op accepted in the cycle after DONE.
    run_op("b2b_mul",  MD_MUL,  32'd3, 32'd4, 32'd12, 34);
    run_op("b2b_divu", MD_DIVU, 32'd12, 32'd5, 32'd2, 34);

    // Reset in cycle 20 of a DIV clears all outputs.
    md_req   = 1'b1;
    md_func3 = MD_DIV;
    md_op_a  = 32'd1000;
    md_op_b  = 32'd3;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("rst pre stall", {31'd0, md_stall}, 32'd1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst cyc stall", {31'd0, md_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    md_req = 1'b0;
    @(negedge clk);
    check("rst after stall", {31'd0, md_stall}, 32'd0);
    check("rst after done", {31'd0, md_done}, 32'd0);
    check("rst after result", md_result, 32'd0);
    @(posedge clk);
    #1;
    last_res = 32'd0;
    run_op("post_rst", MD_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
